dmem_arbiter: RTL and testbench

- Shares the single data memory port between the CPU datapath (load/store path driven by control_logic and the a/b address mux) and a host port.
- The host port is used by the testbench or loader for preload and readback.
- CPU has default priority. A starvation counter forces a host grant after a bounded number of refused cycles, and the CPU is stalled for that cycle.
- Sits between top_level's load/store signals and data_memory.

---
 rtl/dmem_arbiter.sv | 88 ++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: the CPU load/store path has priority, and the host
// port gets a forced grant after a bounded number of refused cycles.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_load,
    input  logic          cpu_stor,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic       cpu_act;
    logic       forced;
    logic       host_rd;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;

    assign cpu_act = cpu_load | cpu_stor;
    assign forced  = (starve_cnt == SMAX);

    // Grant and stall are masked while reset is high so no access escapes.
    assign host_gnt  = ~reset & host_req & (~cpu_act | forced);
    assign cpu_stall = cpu_act & host_gnt;
    assign host_rd   = host_gnt & ~host_we;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (reset) begin
            mem_we = 1'b0;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end else begin
            mem_we = cpu_stor & ~cpu_stall;
        end
    end

    assign cpu_rdata = host_gnt ? '0 : mem_rdata;

    // Count consecutive refusals; any grant or withdrawal restarts the count.
    always_comb begin
        starve_nxt = '0;
        if (host_req && !host_gnt) begin
            if (starve_cnt != SMAX) begin
                starve_nxt = starve_cnt + 4'd1;
            end else begin
                starve_nxt = starve_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            host_rdata <= '0;
            host_valid <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            host_valid <= host_rd;
            if (host_rd) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed corner sequences, a combinational priority
// table, then random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_load;
    logic       cpu_stor;
    logic [7:0] cpu_rdata;
    logic       cpu_stall;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_valid;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_load(cpu_load), .cpu_stor(cpu_stor),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_valid(host_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Reference model state
    logic [7:0] ref_mem [256];
    int         refusals;
    logic       exp_valid;
    logic [7:0] exp_hrdata;

    int n_vec;
    int n_bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        refusals   = 0;
        exp_valid  = 1'b0;
        exp_hrdata = 8'h00;
    endtask

    task automatic set_idle();
        cpu_load   = 1'b0;
        cpu_stor   = 1'b0;
        cpu_addr   = 8'h00;
        cpu_wdata  = 8'h00;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
    endtask

    // One full cycle, entered and left at posedge+1.
    task automatic run_cycle(input logic ld, input logic st,
                             input logic [7:0] ca, input logic [7:0] cd,
                             input logic hr, input logic hw,
                             input logic [7:0] ha, input logic [7:0] hd,
                             output logic g, output logic [7:0] rd);
        logic       e_gnt;
        logic       e_stall;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_rd;
        cpu_load   = ld;
        cpu_stor   = st;
        cpu_addr   = ca;
        cpu_wdata  = cd;
        host_req   = hr;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        e_gnt   = hr && (!(ld || st) || refusals == SM);
        e_stall = (ld || st) && e_gnt;
        e_we    = e_gnt ? hw : st;
        e_addr  = e_gnt ? ha : ca;
        e_rd    = e_gnt ? 8'h00 : ref_mem[ca];
        @(negedge clk);
        chk("host_gnt", host_gnt, e_gnt);
        chk("cpu_stall", cpu_stall, e_stall);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("cpu_rdata", cpu_rdata, e_rd);
        if (e_we) chk("mem_wdata", mem_wdata, e_gnt ? hd : cd);
        g  = host_gnt;
        rd = cpu_rdata;
        if (e_gnt) begin
            if (hw) ref_mem[ha] = hd;
            else exp_hrdata = ref_mem[ha];
            exp_valid = !hw;
        end else begin
            if (st) ref_mem[ca] = cd;
            exp_valid = 1'b0;
        end
        refusals = (!hr || e_gnt) ? 0 : refusals + 1;
        @(posedge clk);
        #1;
        chk("host_valid", host_valid, exp_valid);
        chk("host_rdata", host_rdata, exp_hrdata);
    endtask

    typedef struct {
        logic ld;
        logic st;
        logic hr;
        logic hw;
        logic gnt;
        logic stall;
        logic we;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       g;
        logic [7:0] rd;
        logic [7:0] pat;
        logic       hp;
        logic       hw_r;
        logic [7:0] ha_r;
        logic [7:0] hd_r;
        n_vec = 0;
        n_bad = 0;
        model_reset();
        set_idle();

        // Reset: outputs quiet even with both sides requesting.
        reset    = 1'b1;
        cpu_stor = 1'b1;
        host_req = 1'b1;
        host_we  = 1'b1;
        #3;
        chk("rst_gnt", host_gnt, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_valid", host_valid, 1'b0);
        chk("rst_hrdata", host_rdata, 8'h00);
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Host preload then readback, CPU idle.
        run_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, g, rd);
        chk("pre_wr_gnt", g, 1'b1);
        run_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, g, rd);
        chk("pre_rd_gnt", g, 1'b1);
        chk("pre_valid", host_valid, 1'b1);
        chk("pre_rdata", host_rdata, 8'h5A);

        // CPU stores every cycle: forced host grant on the fifth.
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 1, 8'h20, 8'h33, 1, 0, 8'h20, 8'h00, g, rd);
            pat[i] = g;
        end
        chk("starve_pat", pat, 8'b0001_0000);
        chk("starve_rdata", host_rdata, 8'h33);

        // Load and store together: the store wins.
        run_cycle(1, 1, 8'h05, 8'hC1, 0, 0, 8'h00, 8'h00, g, rd);
        run_cycle(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, g, rd);
        chk("ldst_rdata", rd, 8'hC1);

        // Withdrawal after two refusals restarts the count.
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(0, 1, 8'h06, 8'(i), (i != 2), 0, 8'h05, 8'h00, g, rd);
            pat[i] = g;
        end
        chk("withdraw_pat", pat, 8'b1000_0000);

        // Asynchronous reset while a host read is granted.
        cpu_load  = 1'b0;
        cpu_stor  = 1'b0;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        #1;
        chk("mid_gnt_pre", host_gnt, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_gnt", host_gnt, 1'b0);
        chk("mid_we", mem_we, 1'b0);
        chk("mid_hrdata", host_rdata, 8'h00);
        chk("mid_valid", host_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_valid_edge", host_valid, 1'b0);
        set_idle();
        reset = 1'b0;
        model_reset();
        run_cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, g, rd);
        chk("post_gnt", g, 1'b1);
        chk("post_rdata", host_rdata, 8'h5A);

        // Preload a small address window used by the table and random phase.
        for (int a = 0; a < 32; a++) begin
            run_cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'(a), 8'($urandom), g, rd);
        end
        run_cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, g, rd);

        // Combinational priority table with no refusals accumulated.
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 1, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 1, 1, 1, 0, 1};
        tbl[6] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 0, 0, 0, 1};
        tbl[8] = '{1, 1, 1, 1, 0, 0, 1};
        tbl[9] = '{0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cpu_load   = tbl[i].ld;
            cpu_stor   = tbl[i].st;
            cpu_addr   = 8'h11;
            cpu_wdata  = 8'h77;
            host_req   = tbl[i].hr;
            host_we    = tbl[i].hw;
            host_addr  = 8'h22;
            host_wdata = 8'h99;
            #2;
            chk("tbl_gnt", host_gnt, tbl[i].gnt);
            chk("tbl_stall", cpu_stall, tbl[i].stall);
            chk("tbl_we", mem_we, tbl[i].we);
            chk("tbl_addr", mem_addr, tbl[i].gnt ? 8'h22 : 8'h11);
            chk("tbl_rdata", cpu_rdata,
                tbl[i].gnt ? 8'h00 : ref_mem[8'h11]);
            set_idle();
            @(posedge clk);
            #1;
        end

        // Random traffic; host fields stay stable until granted.
        hp   = 1'b0;
        hw_r = 1'b0;
        ha_r = 8'h00;
        hd_r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            logic       ld;
            logic       st;
            logic [7:0] ca;
            if (!hp && ($urandom % 3 == 0)) begin
                hp   = 1'b1;
                hw_r = 1'($urandom);
                ha_r = 8'($urandom_range(0, 31));
                hd_r = 8'($urandom);
            end
            ld = ($urandom % 10) < 6;
            st = ($urandom % 10) < 4;
            ca = 8'($urandom_range(0, 31));
            run_cycle(ld, st, ca, 8'($urandom), hp, hw_r, ha_r, hd_r, g, rd);
            if (g) hp = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
